// File: rtl/day2_range_scheduler.sv
// Range scheduler: dispatches [start,end] ranges round-robin onto free checker
// units, collects their partial sums through one round-robin arbiter into
// id_sum, and raises done once the final range has been fully summed.
module day2_range_scheduler #(
  parameter int W         = 48,
  parameter int NUM_UNITS = 38
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_start,
  input  logic [W-1:0]           in_end,
  input  logic                   in_last,
  output logic [NUM_UNITS-1:0]   unit_start,
  output logic [W-1:0]           unit_lo,
  output logic [W-1:0]           unit_hi,
  input  logic [NUM_UNITS-1:0]   unit_res_valid,
  input  logic [NUM_UNITS*W-1:0] unit_res,
  output logic [NUM_UNITS-1:0]   unit_res_ack,
  output logic [W-1:0]           id_sum,
  output logic                   done,
  output logic                   bad_range,
  output logic                   proto_err
);

  localparam int          PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int unsigned NU = NUM_UNITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state;
  logic [NUM_UNITS-1:0] owned;
  logic [PW-1:0]        disp_ptr;
  logic [PW-1:0]        coll_ptr;
  logic [PW-1:0]        disp_sel;
  logic [PW-1:0]        coll_sel;
  logic                 disp_found;
  logic                 coll_found;
  logic [NUM_UNITS-1:0] coll_req;
  logic [NUM_UNITS-1:0] disp_mask;
  logic [W-1:0]         coll_val;
  logic                 accept;
  logic                 range_ok;
  logic                 collecting;

  // (base + off) mod NUM_UNITS, with off < NUM_UNITS
  function automatic logic [PW-1:0] ring_idx(input logic [PW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NU) s = s - NU;
    return PW'(s);
  endfunction

  assign in_ready   = (state == S_RUN) && !(&owned);
  assign accept     = in_valid && in_ready;
  assign range_ok   = (in_start <= in_end);
  // clear outranks collection, so no result is consumed in a clear cycle
  assign collecting = ((state == S_RUN) || (state == S_DRAIN)) && !clear;
  assign coll_req   = unit_res_valid & owned & {NUM_UNITS{collecting}};
  assign coll_val   = unit_res[int'(coll_sel) * W +: W];

  // First free unit at or after the dispatch pointer
  always_comb begin
    disp_sel   = '0;
    disp_found = 1'b0;
    for (int unsigned k = 0; k < NU; k++) begin
      if (!disp_found && !owned[ring_idx(disp_ptr, k)]) begin
        disp_found = 1'b1;
        disp_sel   = ring_idx(disp_ptr, k);
      end
    end
  end

  // First requesting unit at or after the collect pointer
  always_comb begin
    coll_sel   = '0;
    coll_found = 1'b0;
    for (int unsigned k = 0; k < NU; k++) begin
      if (!coll_found && coll_req[ring_idx(coll_ptr, k)]) begin
        coll_found = 1'b1;
        coll_sel   = ring_idx(coll_ptr, k);
      end
    end
  end

  // One-hot dispatch and acknowledge masks
  always_comb begin
    disp_mask    = '0;
    unit_res_ack = '0;
    if (accept && range_ok && disp_found) disp_mask[disp_sel] = 1'b1;
    if (coll_found) unit_res_ack[coll_sel] = 1'b1;
  end

  // Control FSM, ownership, dispatch registers and accumulator
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      owned      <= '0;
      disp_ptr   <= '0;
      coll_ptr   <= '0;
      unit_start <= '0;
      unit_lo    <= '0;
      unit_hi    <= '0;
      id_sum     <= '0;
      done       <= 1'b0;
      bad_range  <= 1'b0;
      proto_err  <= 1'b0;
    end else if (clear) begin
      state      <= S_IDLE;
      owned      <= '0;
      disp_ptr   <= '0;
      coll_ptr   <= '0;
      unit_start <= '0;
      unit_lo    <= '0;
      unit_hi    <= '0;
      id_sum     <= '0;
      done       <= 1'b0;
      bad_range  <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      unit_start <= disp_mask;
      owned      <= (owned | disp_mask) & ~unit_res_ack;
      if (|(unit_res_valid & ~owned)) proto_err <= 1'b1;

      case (state)
        S_IDLE:  if (en) state <= S_RUN;
        S_RUN:   if (accept && in_last) state <= S_DRAIN;
        S_DRAIN: if (owned == '0 && !coll_found) begin
                   state <= S_DONE;
                   done  <= 1'b1;
                 end
        default: state <= state;
      endcase

      if (accept) begin
        if (range_ok) begin
          unit_lo  <= in_start;
          unit_hi  <= in_end;
          disp_ptr <= ring_idx(disp_sel, 1);
        end else begin
          bad_range <= 1'b1;
        end
      end

      if (coll_found) begin
        id_sum   <= id_sum + coll_val;
        coll_ptr <= ring_idx(coll_sel, 1);
      end
    end
  end

endmodule

// File: tb/tb_day2_range_scheduler.sv
// Self-checking bench for day2_range_scheduler (W=8, NUM_UNITS=4).
// A behavioural unit model returns lo+hi after a fixed delay; launches are
// checked against a scoreboard queue filled when each range is accepted.
module tb_day2_range_scheduler;
  localparam int TW    = 8;
  localparam int TN    = 4;
  localparam int DELAY = 5;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            en = 1'b0;
  logic            clear = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic [TW-1:0]   in_start = '0;
  logic [TW-1:0]   in_end = '0;
  logic            in_ready;
  logic [TN-1:0]   unit_start;
  logic [TW-1:0]   unit_lo, unit_hi, id_sum;
  logic [TN-1:0]   unit_res_valid, unit_res_ack;
  logic [TN*TW-1:0] unit_res;
  logic            done, bad_range, proto_err;

  // unit model state
  logic [TN-1:0]   res_valid_m = '0;
  logic [TN-1:0]   pend = '0;
  logic [TN-1:0]   hold_mask = '0;
  logic [TN-1:0]   rogue = '0;
  logic [TW-1:0]   rval [TN];
  int              cnt [TN];
  int              ack_cyc [TN];
  int              ack_cnt = 0;
  int              cyc = 0;
  int              n_starts = 0;

  typedef struct { int unit; logic [TW-1:0] lo; logic [TW-1:0] hi; bit good; } sb_t;
  sb_t sb [$];

  typedef struct { logic [TW-1:0] lo; logic [TW-1:0] hi; int unit; int exp_sum; bit exp_bad; } vec_t;
  vec_t vec [3];

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cyc  = 0;
  int done_cyc = 0;

  day2_range_scheduler #(.W(TW), .NUM_UNITS(TN)) dut (
    .clock(clock), .reset(reset), .en(en), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_start(in_start), .in_end(in_end),
    .in_last(in_last), .unit_start(unit_start), .unit_lo(unit_lo), .unit_hi(unit_hi),
    .unit_res_valid(unit_res_valid), .unit_res(unit_res), .unit_res_ack(unit_res_ack),
    .id_sum(id_sum), .done(done), .bad_range(bad_range), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (unit_start != '0) n_starts <= n_starts + 1;

  assign unit_res_valid = res_valid_m | rogue;
  always_comb begin
    unit_res = '0;
    for (int i = 0; i < TN; i++) unit_res[i*TW +: TW] = rval[i];
  end

  // Checker-unit model: sample at negedge, update just after posedge
  initial begin
    logic [TN-1:0] st, ak;
    logic [TW-1:0] lo, hi;
    int c;
    for (int i = 0; i < TN; i++) begin rval[i] = '0; cnt[i] = 0; ack_cyc[i] = 0; end
    forever begin
      @(negedge clock);
      st = unit_start; ak = unit_res_ack; lo = unit_lo; hi = unit_hi; c = cyc;
      @(posedge clock); #1;
      if (reset) begin
        res_valid_m = '0;
        pend = '0;
      end else begin
        for (int i = 0; i < TN; i++) begin
          if (ak[i]) begin
            res_valid_m[i] = 1'b0;
            ack_cnt = ack_cnt + 1;
            ack_cyc[i] = c;
          end
          if (st[i]) begin
            pend[i] = 1'b1;
            cnt[i]  = DELAY;
            rval[i] = lo + hi;
          end else if (pend[i]) begin
            if (cnt[i] > 0) cnt[i] = cnt[i] - 1;
            if (cnt[i] == 0 && !hold_mask[i]) begin
              res_valid_m[i] = 1'b1;
              pend[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_clear();
    @(posedge clock); #1 clear = 1'b1;
    @(posedge clock); #1 clear = 1'b0;
  endtask

  // Offer one range, wait for acceptance, then check the launch one cycle later
  task automatic send(input logic [TW-1:0] lo, input logic [TW-1:0] hi, input logic last, input int u);
    sb_t e;
    bit got;
    @(posedge clock); #1;
    in_valid = 1'b1; in_start = lo; in_end = hi; in_last = last;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clock);
      if (in_ready) got = 1;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: range %0d-%0d never accepted, required within 60 cycles", lo, hi);
      @(posedge clock); #1 in_valid = 1'b0; in_last = 1'b0;
      return;
    end
    acc_cyc = cyc;
    e.unit = u; e.lo = lo; e.hi = hi; e.good = (lo <= hi);
    sb.push_back(e);
    @(posedge clock); #1 in_valid = 1'b0; in_last = 1'b0;
    @(negedge clock);
    e = sb.pop_front();
    if (e.good) begin
      chk("launch_onehot", 32'(unit_start), 32'(4'b0001 << e.unit));
      chk("launch_lo", 32'(unit_lo), 32'(e.lo));
      chk("launch_hi", 32'(unit_hi), 32'(e.hi));
    end else begin
      chk("no_launch_bad", 32'(unit_start), 32'd0);
    end
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clock);
      if (done) got = 1;
    end
    done_cyc = cyc;
    chk("done_reached", 32'(got), 32'd1);
  endtask

  initial begin
    int base_acks, base_starts;
    bit got;
    vec[0] = '{lo: 8'd11, hi: 8'd22, unit: 0, exp_sum: 33, exp_bad: 1'b0};
    vec[1] = '{lo: 8'd30, hi: 8'd10, unit: 0, exp_sum: 0,  exp_bad: 1'b1};
    vec[2] = '{lo: 8'd7,  hi: 8'd7,  unit: 0, exp_sum: 14, exp_bad: 1'b0};

    // reset state, asynchronous: checked before the first clock edge
    #3;
    chk("reset_ctrl", 32'({in_ready, unit_start, unit_res_ack, done, bad_range, proto_err}), 32'd0);
    chk("reset_sum", 32'(id_sum), 32'd0);
    chk("reset_bus", 32'({unit_lo, unit_hi}), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    en = 1'b1;
    @(negedge clock); @(negedge clock);
    chk("ready_in_run", 32'(in_ready), 32'd1);

    // single-range cases: normal, start>end, one-ID range
    for (int v = 0; v < 3; v++) begin
      do_clear();
      base_acks = ack_cnt; base_starts = n_starts;
      send(vec[v].lo, vec[v].hi, 1'b1, vec[v].unit);
      wait_done();
      chk("single_sum", 32'(id_sum), 32'(vec[v].exp_sum));
      chk("single_bad", 32'(bad_range), 32'(vec[v].exp_bad));
      chk("single_acks", 32'(ack_cnt - base_acks), vec[v].exp_bad ? 32'd0 : 32'd1);
      chk("single_starts", 32'(n_starts - base_starts), vec[v].exp_bad ? 32'd0 : 32'd1);
      if (!vec[v].exp_bad) chk("done_latency", 32'(done_cyc - ack_cyc[0] <= 2), 32'd1);
    end

    // six ranges on four held units, then free units one at a time
    do_clear();
    hold_mask = 4'hF;
    send(8'd1, 8'd2, 1'b0, 0);
    send(8'd3, 8'd4, 1'b0, 1);
    send(8'd5, 8'd6, 1'b0, 2);
    send(8'd7, 8'd8, 1'b0, 3);
    chk("full_not_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clock);
    chk("full_still_not_ready", 32'(in_ready), 32'd0);
    hold_mask = 4'hE;
    send(8'd9, 8'd10, 1'b0, 0);
    chk("reaccept_after_ack", 32'(acc_cyc - ack_cyc[0]), 32'd1);
    hold_mask = 4'h0;
    send(8'd11, 8'd12, 1'b1, 1);
    wait_done();
    chk("six_sum", 32'(id_sum), 32'd78);

    // four results raised in the same cycle
    do_clear();
    hold_mask = 4'hF;
    base_acks = ack_cnt;
    send(8'd0, 8'd1, 1'b0, 0);
    send(8'd1, 8'd1, 1'b0, 1);
    send(8'd1, 8'd2, 1'b0, 2);
    send(8'd2, 8'd2, 1'b1, 3);
    repeat (8) @(negedge clock);
    hold_mask = 4'h0;
    wait_done();
    chk("burst_acks", 32'(ack_cnt - base_acks), 32'd4);
    chk("burst_order1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd1);
    chk("burst_order2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd1);
    chk("burst_order3", 32'(ack_cyc[3] - ack_cyc[2]), 32'd1);
    chk("burst_sum", 32'(id_sum), 32'd10);

    // accumulator wrap modulo 2^W
    do_clear();
    send(8'd100, 8'd100, 1'b0, 0);
    send(8'd50, 8'd50, 1'b1, 1);
    wait_done();
    chk("wrap_sum", 32'(id_sum), 32'd44);
    chk("wrap_flags", 32'({bad_range, proto_err}), 32'd0);

    // result from a unit that owns nothing
    do_clear();
    repeat (2) @(negedge clock);
    @(posedge clock); #1 rogue = 4'b0100;
    @(negedge clock);
    chk("rogue_no_ack", 32'(unit_res_ack), 32'd0);
    @(posedge clock); #1 rogue = 4'b0000;
    @(negedge clock);
    chk("proto_err_set", 32'(proto_err), 32'd1);
    do_clear();
    @(negedge clock);
    chk("proto_err_cleared", 32'(proto_err), 32'd0);

    // asynchronous reset in the middle of draining
    do_clear();
    hold_mask = 4'hF;
    send(8'd1, 8'd1, 1'b0, 0);
    send(8'd2, 8'd2, 1'b1, 1);
    repeat (8) @(negedge clock);
    hold_mask = 4'h0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      if (id_sum != '0) got = 1;
    end
    chk("drain_partial", 32'(got), 32'd1);
    chk("drain_not_ready", 32'(in_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_ctrl", 32'({in_ready, unit_start, unit_res_ack, done, bad_range, proto_err}), 32'd0);
    chk("async_reset_sum", 32'(id_sum), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("post_reset_sum", 32'({id_sum, done}), 32'd0);
    send(8'd5, 8'd6, 1'b1, 0);
    wait_done();
    chk("restart_sum", 32'(id_sum), 32'd11);
    chk("restart_flags", 32'({bad_range, proto_err}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
